// File: rtl/decoder_erasure_flag_scan_pkg.sv
// Shared RS decoder constants, scan FSM states and the address-to-position mapping
// used by the erasure flag scanner.
package decoder_erasure_flag_scan_pkg;

    localparam int N        = 255;
    localparam int K        = 239;
    localparam int MAX_ERAS = N - K;
    localparam int ADDR_W   = 8;
    localparam int CNT_W    = 5;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FLUSH
    } scan_state_t;

    // RS position of a symbol: address 0 holds the highest-degree coefficient.
    function automatic logic [ADDR_W-1:0] rs_pos(input logic [ADDR_W-1:0] addr);
        return ADDR_W'(N - 1) - addr;
    endfunction

endpackage

// File: rtl/decoder_erasure_pos_fifo.sv
// Two-entry position FIFO between the flag RAM return path and the locator stream.
// Push and pop in the same cycle are both honoured.
module decoder_erasure_pos_fifo
    import decoder_erasure_flag_scan_pkg::*;
#(
    parameter int W = ADDR_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop & (count != 2'd0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & ((count != 2'd2) | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/decoder_erasure_flag_scan.sv
// Scans the per-codeword erasure flag RAM and streams erasure positions (descending)
// to the locator builder, tracking a saturating erasure count and overflow.
module decoder_erasure_flag_scan
    import decoder_erasure_flag_scan_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rdaddress,
    output logic              rden,
    input  logic              q,
    output logic              eras_valid,
    input  logic              eras_ready,
    output logic [ADDR_W-1:0] eras_pos,
    output logic [CNT_W-1:0]  eras_count,
    output logic              eras_overflow
);

    scan_state_t       state;
    scan_state_t       state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              inflight;
    logic              ret_hit;
    logic              ret_ovf;
    logic              push;
    logic              pop;
    logic              credit;
    logic [1:0]        fifo_cnt;
    logic [ADDR_W-1:0] fifo_dout;

    assign ret_hit    = inflight & q;
    assign ret_ovf    = ret_hit & (eras_count == CNT_W'(MAX_ERAS));
    assign push       = ret_hit & ~ret_ovf;
    // Every issued read has a guaranteed FIFO slot, so backpressure never drops a flag.
    assign credit     = (3'(fifo_cnt) + 3'(inflight)) < 3'd2;
    assign eras_valid = (fifo_cnt != 2'd0);
    assign eras_pos   = fifo_dout;
    assign pop        = eras_valid & eras_ready;
    assign busy       = (state != IDLE);
    assign rdaddress  = rden ? ptr : rd_addr_q;

    always_comb begin
        state_nxt = state;
        rden      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = SCAN;
            end
            SCAN: begin
                // The overflowing return also blocks the read issued alongside it.
                rden = credit & ~ret_ovf;
                if (ret_ovf || (rden && ptr == ADDR_W'(N - 1)))
                    state_nxt = FLUSH;
            end
            FLUSH: begin
                if (!inflight && fifo_cnt == 2'd0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= '0;
            rd_addr_q     <= '0;
            inflight      <= 1'b0;
            eras_count    <= '0;
            eras_overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= rden;
            if (rden) begin
                rd_addr_q <= ptr;
                if (ptr != ADDR_W'(N - 1))
                    ptr <= ptr + ADDR_W'(1);
            end
            if (state == IDLE && start) begin
                ptr           <= '0;
                eras_count    <= '0;
                eras_overflow <= 1'b0;
            end else if (ret_ovf) begin
                eras_count    <= CNT_W'(MAX_ERAS + 1);
                eras_overflow <= 1'b1;
            end else if (push) begin
                eras_count <= eras_count + CNT_W'(1);
            end
        end
    end

    decoder_erasure_pos_fifo #(
        .W (ADDR_W)
    ) u_pos_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (rs_pos(rd_addr_q)),
        .dout  (fifo_dout),
        .count (fifo_cnt)
    );

endmodule
